// File: rtl/braille_pkg.sv
// Shared definitions for the Braille cell driver: widths, FSM states and
// the lowercase ASCII to 6-dot cell mapping (bit k drives dot k+1).
package braille_pkg;

  localparam int DOT_W   = 6;
  localparam int ASCII_W = 8;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_SHOW = 2'd1,
    ST_GAP  = 2'd2
  } state_e;

  function automatic logic is_legal_alpha(input logic [ASCII_W-1:0] ascii);
    return (ascii >= 8'h61) && (ascii <= 8'h7a);
  endfunction

  // Non-letters map to a blank cell; callers only show legal chars anyway.
  function automatic logic [DOT_W-1:0] ascii_to_braille(input logic [ASCII_W-1:0] ascii);
    logic [DOT_W-1:0] dots;
    dots = '0;
    case (ascii)
      8'h61: dots = 6'b000001;
      8'h62: dots = 6'b000011;
      8'h63: dots = 6'b001001;
      8'h64: dots = 6'b011001;
      8'h65: dots = 6'b010001;
      8'h66: dots = 6'b001011;
      8'h67: dots = 6'b011011;
      8'h68: dots = 6'b010011;
      8'h69: dots = 6'b001010;
      8'h6a: dots = 6'b011010;
      8'h6b: dots = 6'b000101;
      8'h6c: dots = 6'b000111;
      8'h6d: dots = 6'b001101;
      8'h6e: dots = 6'b011101;
      8'h6f: dots = 6'b010101;
      8'h70: dots = 6'b001111;
      8'h71: dots = 6'b011111;
      8'h72: dots = 6'b010111;
      8'h73: dots = 6'b001110;
      8'h74: dots = 6'b011110;
      8'h75: dots = 6'b100101;
      8'h76: dots = 6'b100111;
      8'h77: dots = 6'b111010;
      8'h78: dots = 6'b101101;
      8'h79: dots = 6'b111101;
      8'h7a: dots = 6'b110101;
      default: dots = '0;
    endcase
    return dots;
  endfunction

endpackage

// File: rtl/braille_char_fifo.sv
// Small synchronous character FIFO with first-word-fall-through read data.
// A write into a full FIFO is still accepted when a pop happens in the same cycle.
module braille_char_fifo
  import braille_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int WIDTH = ASCII_W
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             wr_en,
  input  logic [WIDTH-1:0] wr_data,
  input  logic             rd_en,
  output logic [WIDTH-1:0] rd_data,
  output logic             empty,
  output logic             wr_drop
);

  localparam int AW = $clog2(DEPTH);

  logic [AW:0]      wr_ptr_q, wr_ptr_d;
  logic [AW:0]      rd_ptr_q, rd_ptr_d;
  logic [WIDTH-1:0] mem_q [DEPTH];
  logic             full;
  logic             do_wr;
  logic             do_rd;

  // The extra pointer bit separates full from empty when the indices match.
  assign empty = (wr_ptr_q == rd_ptr_q);
  assign full  = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                 (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);

  assign do_rd   = rd_en && !empty;
  assign do_wr   = wr_en && (!full || do_rd);
  assign wr_drop = wr_en && !do_wr;
  assign rd_data = mem_q[rd_ptr_q[AW-1:0]];

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (do_wr) wr_ptr_d = wr_ptr_q + (AW+1)'(1);
    if (do_rd) rd_ptr_d = rd_ptr_q + (AW+1)'(1);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      if (do_wr) mem_q[wr_ptr_q[AW-1:0]] <= wr_data;
    end
  end

endmodule

// File: rtl/braille_cell_driver.sv
// Buffers classifier chars and shows each as a Braille cell for a hold time
// followed by a blank gap.
//
//   state   | meaning
//   --------+--------------------------------------------------
//   ST_IDLE | nothing shown, waiting for a buffered char
//   ST_SHOW | cell driven on o_dots for HOLD_CYCLES clocks
//   ST_GAP  | blank cell for GAP_CYCLES clocks before next char
module braille_cell_driver
  import braille_pkg::*;
#(
  parameter int HOLD_CYCLES = 100_000_000,
  parameter int GAP_CYCLES  = 10_000_000,
  parameter int FIFO_DEPTH  = 4
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic               i_valid,
  input  logic [ASCII_W-1:0] i_alpha,
  input  logic               i_clr_ovf,
  output logic [DOT_W-1:0]   o_dots,
  output logic               o_dots_valid,
  output logic [ASCII_W-1:0] o_char,
  output logic               o_busy,
  output logic               o_invalid,
  output logic               o_overflow
);

  localparam int MAX_CYC = (HOLD_CYCLES > GAP_CYCLES) ? HOLD_CYCLES : GAP_CYCLES;
  localparam int CNT_W   = $clog2(MAX_CYC + 1);
  localparam logic [CNT_W-1:0] HOLD_LOAD = CNT_W'(HOLD_CYCLES - 1);
  localparam logic [CNT_W-1:0] GAP_LOAD  = CNT_W'((GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0);

  logic               in_vld_q, in_vld_d;
  logic [ASCII_W-1:0] in_char_q, in_char_d;
  logic               invalid_q, invalid_d;
  logic               ovf_q, ovf_d;

  state_e             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [DOT_W-1:0]   dots_q, dots_d;
  logic [ASCII_W-1:0] char_q, char_d;

  logic               pop;
  logic               slot_free;
  logic               fifo_empty;
  logic               fifo_drop;
  logic [ASCII_W-1:0] fifo_rd_data;

  braille_char_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (ASCII_W)
  ) u_fifo (
    .clk     (clk),
    .reset_n (reset_n),
    .wr_en   (in_vld_q),
    .wr_data (in_char_q),
    .rd_en   (pop),
    .rd_data (fifo_rd_data),
    .empty   (fifo_empty),
    .wr_drop (fifo_drop)
  );

  // Legal strobes are staged one cycle before the FIFO write.
  always_comb begin
    in_vld_d  = i_valid && is_legal_alpha(i_alpha);
    in_char_d = i_alpha;
    invalid_d = i_valid && !is_legal_alpha(i_alpha);
    ovf_d     = ovf_q;
    if (i_clr_ovf) ovf_d = 1'b0;
    if (fifo_drop) ovf_d = 1'b1;
  end

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    dots_d    = dots_q;
    char_d    = char_q;
    pop       = 1'b0;
    slot_free = 1'b0;
    case (state_q)
      ST_IDLE: slot_free = 1'b1;
      ST_SHOW: begin
        if (cnt_q == '0) begin
          if (GAP_CYCLES == 0) begin
            slot_free = 1'b1;
          end else begin
            state_d = ST_GAP;
            cnt_d   = GAP_LOAD;
            dots_d  = '0;
          end
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      ST_GAP: begin
        if (cnt_q == '0) slot_free = 1'b1;
        else             cnt_d     = cnt_q - CNT_W'(1);
      end
      default: state_d = ST_IDLE;
    endcase

    // End of a char (or idle): pop straight into SHOW without an idle cycle.
    if (slot_free) begin
      if (!fifo_empty) begin
        pop     = 1'b1;
        state_d = ST_SHOW;
        cnt_d   = HOLD_LOAD;
        dots_d  = ascii_to_braille(fifo_rd_data);
        char_d  = fifo_rd_data;
      end else begin
        state_d = ST_IDLE;
        cnt_d   = '0;
        dots_d  = '0;
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      in_vld_q  <= 1'b0;
      in_char_q <= '0;
      invalid_q <= 1'b0;
      ovf_q     <= 1'b0;
      state_q   <= ST_IDLE;
      cnt_q     <= '0;
      dots_q    <= '0;
      char_q    <= '0;
    end else begin
      in_vld_q  <= in_vld_d;
      in_char_q <= in_char_d;
      invalid_q <= invalid_d;
      ovf_q     <= ovf_d;
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      dots_q    <= dots_d;
      char_q    <= char_d;
    end
  end

  assign o_dots       = dots_q;
  assign o_dots_valid = (state_q == ST_SHOW);
  assign o_char       = char_q;
  assign o_busy       = (state_q != ST_IDLE) || !fifo_empty;
  assign o_invalid    = invalid_q;
  assign o_overflow   = ovf_q;

endmodule
